// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer with error flags, overflow and error statistics
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter bit DROP_ERRORED = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    input  logic                     wr_parity_err,
    input  logic                     wr_stop_err,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    output logic                     rd_stop_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               err_count,
    input  logic                     clear_status
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          has_err;
    logic          store;
    logic          pop;
    logic          push;
    logic          ovf_evt;
    logic          err_evt;

    assign has_err  = wr_parity_err | wr_stop_err;
    assign store    = wr_valid && !(DROP_ERRORED && has_err);
    assign rd_valid = count != '0;
    assign full     = count == FULL_LVL;
    assign pop      = rd_valid && rd_ready;
    assign push     = store && (!full || pop);
    assign ovf_evt  = store && full && !pop;
    assign err_evt  = wr_valid && has_err;
    assign {rd_stop_err, rd_parity_err, rd_data} = rd_valid ? mem[rd_ptr] : 10'd0;

    // Storage array is deliberately not reset; only pointers/count define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wr_stop_err, wr_parity_err, wr_data};
    end

    // Pointers and occupancy; a push and pop in the same cycle leave count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end

    // Sticky overflow and saturating error counter; a same-cycle event beats clear_status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            overflow  <= clear_status ? ovf_evt : (overflow | ovf_evt);
            err_count <= clear_status ? {7'd0, err_evt} :
                         (err_evt && err_count != 8'hFF) ? err_count + 1'b1 : err_count;
        end
    end
endmodule
